// File: rtl/float_multiplier_param.sv
// float_multiplier_param: parameterised IEEE-style multiplier, 5-state FSM.
// Round-to-nearest-even, subnormal inputs flushed to zero.
module float_multiplier_param #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 7,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic [3:0]           flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [2:0] {
    IDLE, MUL, NORM, ROUND, DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_y;
  logic [W-1:0]    r_spec_y;
  logic [3:0]      r_spec_f;
  logic [3:0]      r_flags;
  logic            r_spec;
  logic            r_sign;
  logic            r_out_valid;
  logic [PW-1:0]   r_p;
  logic [EW-1:0]   r_e;

  logic [EXP_W-1:0] w_a_e;
  logic [EXP_W-1:0] w_b_e;
  logic [MAN_W-1:0] w_a_m;
  logic [MAN_W-1:0] w_b_m;
  logic             w_a_zero, w_b_zero;
  logic             w_a_inf, w_b_inf;
  logic             w_a_nan, w_b_nan;
  logic             w_sign;
  logic [PW-1:0]    w_prod;
  logic [EW-1:0]    w_exp_sum;
  logic             w_spec;
  logic [W-1:0]     w_spec_y;
  logic [3:0]       w_spec_f;

  assign w_a_e  = r_a[W-2 -: EXP_W];
  assign w_b_e  = r_b[W-2 -: EXP_W];
  assign w_a_m  = r_a[MAN_W-1:0];
  assign w_b_m  = r_b[MAN_W-1:0];
  assign w_sign = r_a[W-1] ^ r_b[W-1];

  assign w_a_zero = (w_a_e == '0);
  assign w_b_zero = (w_b_e == '0);
  assign w_a_inf  = (&w_a_e) && !(|w_a_m);
  assign w_b_inf  = (&w_b_e) && !(|w_b_m);
  assign w_a_nan  = (&w_a_e) && (|w_a_m);
  assign w_b_nan  = (&w_b_e) && (|w_b_m);

  assign w_prod = PW'({1'b1, w_a_m}) * PW'({1'b1, w_b_m});
  assign w_exp_sum = EW'(w_a_e) + EW'(w_b_e) - EW'(BIAS);

  // Special operands bypass the datapath; priority NaN > Inf > zero.
  always_comb begin
    w_spec   = 1'b0;
    w_spec_y = '0;
    w_spec_f = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero)
        || (w_b_inf && w_a_zero)) begin
      w_spec   = 1'b1;
      w_spec_y = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_spec_f = 4'b1000;
    end else if (w_a_inf || w_b_inf) begin
      w_spec   = 1'b1;
      w_spec_y = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_spec   = 1'b1;
      w_spec_y = {w_sign, {(W-1){1'b0}}};
    end
  end

  logic [MAN_W:0]   w_mant;
  logic             w_guard, w_sticky, w_up, w_carry;
  logic [MAN_W+1:0] w_rnd;
  logic [MAN_W-1:0] w_man_fin;
  logic [EW-1:0]    w_e_fin;
  logic             w_ovf, w_unf, w_inx;
  logic [W-1:0]     w_res_y;
  logic [3:0]       w_res_f;

  assign w_mant    = r_p[PW-1 -: MAN_W+1];
  assign w_guard   = r_p[MAN_W];
  assign w_sticky  = |r_p[MAN_W-1:0];
  assign w_up      = w_guard && (w_sticky || r_p[MAN_W+1]);
  assign w_rnd     = {1'b0, w_mant} + (MAN_W+2)'(w_up);
  assign w_carry   = w_rnd[MAN_W+1];
  assign w_man_fin = w_carry ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_e_fin   = r_e + EW'(w_carry);
  assign w_ovf     = !w_e_fin[EW-1] && (w_e_fin >= EW'(EMAX));
  assign w_unf     = w_e_fin[EW-1] || (w_e_fin == '0);
  assign w_inx     = w_guard || w_sticky;

  always_comb begin
    w_res_y = {r_sign, w_e_fin[EXP_W-1:0], w_man_fin};
    w_res_f = {3'b000, w_inx};
    if (r_spec) begin
      w_res_y = r_spec_y;
      w_res_f = r_spec_f;
    end else if (w_ovf) begin
      w_res_f = 4'b0101;
      if (SATURATE)
        w_res_y = {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else
        w_res_y = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_unf) begin
      w_res_f = 4'b0011;
      w_res_y = {r_sign, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_y         <= '0;
      r_flags     <= '0;
      r_spec      <= 1'b0;
      r_spec_y    <= '0;
      r_spec_f    <= '0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_e         <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_state <= MUL;
        end
        MUL: begin
          r_sign   <= w_sign;
          r_p      <= w_prod;
          r_e      <= w_exp_sum;
          r_spec   <= w_spec;
          r_spec_y <= w_spec_y;
          r_spec_f <= w_spec_f;
          r_state  <= NORM;
        end
        NORM: begin
          if (r_p[PW-1]) r_e <= r_e + EW'(1);
          else           r_p <= {r_p[PW-2:0], 1'b0};
          r_state <= ROUND;
        end
        ROUND: begin
          r_y         <= w_res_y;
          r_flags     <= w_res_f;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_flags     <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign flags     = r_flags;
endmodule

// File: tb/tb_float_multiplier_param.sv
// Bench for float_multiplier_param: bf16-shaped (saturating and Inf)
// plus a 1-4-3 instance, directed and randomized against a value model.
module tb_float_multiplier_param;
  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic [7:0]  as_, bs;
  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [15:0] y0, y1;
  logic [7:0]  y2;
  logic [3:0]  f0, f1, f2;

  int n_checks;
  int n_fail;

  float_multiplier_param #(.EXP_W(8), .MAN_W(7), .SATURATE(1'b1)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready),
    .y(y0), .flags(f0)
  );
  float_multiplier_param #(.EXP_W(8), .MAN_W(7), .SATURATE(1'b0)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
    .y(y1), .flags(f1)
  );
  float_multiplier_param #(.EXP_W(4), .MAN_W(3), .SATURATE(1'b1)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .a(as_), .b(bs), .out_valid(ov2), .out_ready(out_ready),
    .y(y2), .flags(f2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Value-level model: exact significand product, RNE by remainder.
  function automatic void ref_mul(
    input int ew, input int mw, input bit sat,
    input longint av, input longint bv,
    output longint ry, output logic [3:0] rf);
    longint emax, bias, mmask, sa, sb, ea, eb, ma, mb, sp;
    longint prod, e, q, r, half, sh;
    bit na, nb, ia, ib, za, zb, inx;
    emax  = (64'd1 << ew) - 1;
    bias  = (64'd1 << (ew - 1)) - 1;
    mmask = (64'd1 << mw) - 1;
    sa = (av >> (ew + mw)) & 1;
    sb = (bv >> (ew + mw)) & 1;
    ea = (av >> mw) & emax;
    eb = (bv >> mw) & emax;
    ma = av & mmask;
    mb = bv & mmask;
    sp = (sa ^ sb) << (ew + mw);
    na = (ea == emax) && (ma != 0);
    nb = (eb == emax) && (mb != 0);
    ia = (ea == emax) && (ma == 0);
    ib = (eb == emax) && (mb == 0);
    za = (ea == 0);
    zb = (eb == 0);
    rf = 4'b0000;
    if (na || nb || (ia && zb) || (ib && za)) begin
      ry = (emax << mw) | (64'd1 << (mw - 1));
      rf = 4'b1000;
      return;
    end
    if (ia || ib) begin
      ry = sp | (emax << mw);
      return;
    end
    if (za || zb) begin
      ry = sp;
      return;
    end
    prod = ((64'd1 << mw) + ma) * ((64'd1 << mw) + mb);
    e = ea + eb - bias;
    if (prod >= (64'd1 << (2 * mw + 1))) begin
      sh = mw + 1;
      e = e + 1;
    end else begin
      sh = mw;
    end
    q = prod >> sh;
    r = prod & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (r > half || (r == half && (q & 1) == 1)) q = q + 1;
    if (q == (64'd1 << (mw + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    inx = (r != 0);
    if (e >= emax) begin
      rf = 4'b0101;
      if (sat) ry = sp | ((emax - 1) << mw) | mmask;
      else     ry = sp | (emax << mw);
    end else if (e <= 0) begin
      rf = 4'b0011;
      ry = sp;
    end else begin
      rf = {3'b000, inx};
      ry = sp | (e << mw) | (q & mmask);
    end
  endfunction

  // Drives one operation into all three instances and collects results.
  task automatic run_op(
    input logic [15:0] ta, input logic [15:0] tb,
    input logic [7:0] tas, input logic [7:0] tbs,
    output logic [15:0] oy0, output logic [3:0] of0,
    output logic [15:0] oy1, output logic [3:0] of1,
    output logic [7:0] oy2, output logic [3:0] of2,
    output int lat);
    @(negedge clock);
    a = ta; b = tb; as_ = tas; bs = tbs;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!ov0 && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    oy0 = y0; of0 = f0;
    oy1 = y1; of1 = f1;
    oy2 = y2; of2 = f2;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (ov0 !== 1'b0 || y0 !== 16'h0 || f0 !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b y=%h f=%b want 0/0000/0000",
               ov0, y0, f0);
    end
    n_checks++;
    if (rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 0", rdy0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (rdy0 !== 1'b1 || rdy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_in_ready: got %b/%b want 1/1", rdy0, rdy2);
    end
  endtask

  task automatic test_basic();
    @(negedge clock);
    a = 16'h3FC0; b = 16'h4000; as_ = 8'h3C; bs = 8'h3C;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (ov0 !== (k == 4) || rdy0 !== (k == 5)) begin
        n_fail++;
        $display("FAIL basic_timing edge%0d: got ov=%b rdy=%b want %b/%b",
                 k, ov0, rdy0, (k == 4), (k == 5));
      end
      if (k == 4) begin
        n_checks++;
        if (y0 !== 16'h4040 || f0 !== 4'h0) begin
          n_fail++;
          $display("FAIL basic_1p5x2: got %h/%b want 4040/0000", y0, f0);
        end
        n_checks++;
        if (y2 !== 8'h41 || f2 !== 4'h0) begin
          n_fail++;
          $display("FAIL small_1p5x1p5: got %h/%b want 41/0000", y2, f2);
        end
      end
    end
  endtask

  task automatic test_rne();
    logic [15:0] r0, r1;
    logic [7:0]  r2;
    logic [3:0]  g0, g1, g2;
    int lat;
    run_op(16'h3FC0, 16'h3F81, 8'h0, 8'h0, r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h3FC2 || g0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL rne_tie_odd: got %h/%b want 3FC2/0001", r0, g0);
    end
    run_op(16'h3FC0, 16'h3F83, 8'h0, 8'h0, r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h3FC4 || g0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL rne_tie_even: got %h/%b want 3FC4/0001", r0, g0);
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL rne_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] r0, r1;
    logic [7:0]  r2;
    logic [3:0]  g0, g1, g2;
    int lat;
    run_op(16'h7F00, 16'h7F00, 8'h70, 8'h70,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h7F7F || g0 !== 4'b0101) begin
      n_fail++;
      $display("FAIL ovf_saturate: got %h/%b want 7F7F/0101", r0, g0);
    end
    n_checks++;
    if (r1 !== 16'h7F80 || g1 !== 4'b0101) begin
      n_fail++;
      $display("FAIL ovf_inf: got %h/%b want 7F80/0101", r1, g1);
    end
    n_checks++;
    if (r2 !== 8'h77 || g2 !== 4'b0101) begin
      n_fail++;
      $display("FAIL ovf_small: got %h/%b want 77/0101", r2, g2);
    end
    run_op(16'h0080, 16'h0080, 8'h08, 8'h08,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h0000 || g0 !== 4'b0011) begin
      n_fail++;
      $display("FAIL underflow: got %h/%b want 0000/0011", r0, g0);
    end
  endtask

  task automatic test_specials();
    logic [15:0] r0, r1;
    logic [7:0]  r2;
    logic [3:0]  g0, g1, g2;
    int lat;
    run_op(16'h7F80, 16'h0000, 8'h78, 8'h00,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h7FC0 || g0 !== 4'b1000) begin
      n_fail++;
      $display("FAIL inf_x_zero: got %h/%b want 7FC0/1000", r0, g0);
    end
    n_checks++;
    if (r2 !== 8'h7C || g2 !== 4'b1000) begin
      n_fail++;
      $display("FAIL inf_x_zero_small: got %h/%b want 7C/1000", r2, g2);
    end
    run_op(16'h8000, 16'h4000, 8'h80, 8'h40,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h8000 || g0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL negzero_x_two: got %h/%b want 8000/0000", r0, g0);
    end
    run_op(16'h0001, 16'h3F80, 8'h01, 8'h38,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h0000 || g0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL subnormal_ftz: got %h/%b want 0000/0000", r0, g0);
    end
    run_op(16'hFF80, 16'h4000, 8'hF8, 8'h40,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'hFF80 || g0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL neginf_x_two: got %h/%b want FF80/0000", r0, g0);
    end
    run_op(16'h3F80, 16'h7F81, 8'h38, 8'h79,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h7FC0 || g0 !== 4'b1000) begin
      n_fail++;
      $display("FAIL nan_input: got %h/%b want 7FC0/1000", r0, g0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int seen;
    @(negedge clock);
    a = 16'h3FC0; b = 16'h4000; as_ = 8'h3C; bs = 8'h3C;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!ov0 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want 4", n);
    end
    @(negedge clock);
    a = 16'h4000; b = 16'h4000;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (ov0 !== 1'b1 || y0 !== 16'h4040 || f0 !== 4'h0
          || rdy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got ov=%b y=%h f=%b rdy=%b want 1/4040/0000/0",
                 k, ov0, y0, f0, rdy0);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (ov0 !== 1'b0 || f0 !== 4'h0 || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b f=%b rdy=%b want 0/0000/1",
               ov0, f0, rdy0);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (ov0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL bp_second_accepted: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] r0, r1;
    logic [7:0]  r2;
    logic [3:0]  g0, g1, g2;
    int lat;
    int seen;
    @(negedge clock);
    a = 16'h3FC0; b = 16'h4000; as_ = 8'h3C; bs = 8'h3C;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b0 || y0 !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_state: got ov=%b rdy=%b y=%h want 0/0/0000",
               ov0, rdy0, y0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (ov0 || ov2) seen++;
    end
    n_checks++;
    if (seen !== 0 || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got valid_cycles=%0d rdy=%b want 0/1",
               seen, rdy0);
    end
    run_op(16'h3FC0, 16'h4000, 8'h3C, 8'h3C,
           r0, g0, r1, g1, r2, g2, lat);
    n_checks++;
    if (r0 !== 16'h4040 || g0 !== 4'h0 || lat !== 4) begin
      n_fail++;
      $display("FAIL rst_mid_next: got %h/%b lat=%0d want 4040/0000/4",
               r0, g0, lat);
    end
    n_checks++;
    if (r2 !== 8'h41 || g2 !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_mid_next_small: got %h/%b want 41/0000", r2, g2);
    end
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] v;
    logic [7:0]  e;
    v = 16'($urandom);
    if ($urandom_range(0, 7) == 0) e = 8'($urandom);
    else e = 8'($urandom_range(64, 190));
    v[14:7] = e;
    return v;
  endfunction

  task automatic test_random();
    logic [15:0] ta, tb, r0, r1;
    logic [7:0]  tas, tbs, r2;
    logic [3:0]  g0, g1, g2, e0, e1, e2;
    longint      x0, x1, x2;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ta = rnd16();
      tb = rnd16();
      tas = 8'($urandom);
      tbs = 8'($urandom);
      ref_mul(8, 7, 1'b1, longint'(ta), longint'(tb), x0, e0);
      ref_mul(8, 7, 1'b0, longint'(ta), longint'(tb), x1, e1);
      ref_mul(4, 3, 1'b1, longint'(tas), longint'(tbs), x2, e2);
      run_op(ta, tb, tas, tbs, r0, g0, r1, g1, r2, g2, lat);
      n_checks++;
      if (r0 !== x0[15:0] || g0 !== e0) begin
        n_fail++;
        $display("FAIL rand_sat %h*%h: got %h/%b want %h/%b",
                 ta, tb, r0, g0, x0[15:0], e0);
      end
      n_checks++;
      if (r1 !== x1[15:0] || g1 !== e1) begin
        n_fail++;
        $display("FAIL rand_inf %h*%h: got %h/%b want %h/%b",
                 ta, tb, r1, g1, x1[15:0], e1);
      end
      n_checks++;
      if (r2 !== x2[7:0] || g2 !== e2) begin
        n_fail++;
        $display("FAIL rand_small %h*%h: got %h/%b want %h/%b",
                 tas, tbs, r2, g2, x2[7:0], e2);
      end
      n_checks++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL rand_latency: got %0d want 4", lat);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; as_ = '0; bs = '0;
    test_reset();
    test_basic();
    test_rne();
    test_overflow();
    test_specials();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
